// File: rtl/lsu_dmem_if.sv
// rtl/lsu_dmem_if.sv - load/store unit to data-memory bus bridge (optional watchdog: LSU_TIMEOUT_EN)
module lsu_dmem_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic        lsu_busy_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [29:0] waddr_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        done_q, err_q;

    logic        done_d, err_d, load_d, capture;
    logic        legal_c, aligned_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [31:0] ext_c;
    logic        tmo;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog: zero while idle, so it restarts on every entry to REQ
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Decode the incoming command: legality, alignment, lane enables and replicated data
    always_comb begin
        legal_c   = lsu_we_i ? (lsu_funct3_i inside {3'b000, 3'b001, 3'b010})
                             : (lsu_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        aligned_c = 1'b1;
        be_c      = 4'b1111;
        wdata_c   = lsu_wdata_i;
        case (lsu_funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << lsu_addr_i[1:0];
                wdata_c = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                aligned_c = ~lsu_addr_i[0];
                be_c      = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_c   = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                aligned_c = (lsu_addr_i[1:0] == 2'b00);
            end
        endcase
    end

    // Extract the addressed byte/half from the returned word and extend it
    always_comb begin
        shifted = bus_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext_c = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext_c = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext_c = {24'h0, shifted[7:0]};
            3'b101:  ext_c = {16'h0, shifted[15:0]};
            default: ext_c = bus_rdata_i;
        endcase
    end

    // Next state and completion pulses; a bus completion wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_i) begin
                    capture = 1'b1;
                    if (legal_c && aligned_c) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    if (we_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (tmo) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    load_d  = 1'b1;
                end else if (tmo) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, command registers and registered result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            waddr_q <= '0;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (capture) begin
                we_q    <= lsu_we_i;
                f3_q    <= lsu_funct3_i;
                waddr_q <= lsu_addr_i[31:2];
                off_q   <= lsu_addr_i[1:0];
                be_q    <= be_c;
                wdata_q <= wdata_c;
            end
            if (load_d) begin
                rdata_q <= ext_c;
            end
        end
    end

    assign bus_req_o   = (state_q == S_REQ);
    assign bus_addr_o  = {waddr_q, 2'b00};
    assign bus_we_o    = we_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign lsu_rdata_o = rdata_q;
    assign lsu_done_o  = done_q;
    assign lsu_err_o   = err_q;
    assign lsu_busy_o  = (state_q != S_IDLE);

endmodule
